// File: rtl/dmem_responder_pkg.sv
// Shared types and widths for the data-memory responder and its lane aligner.
package dmem_responder_pkg;

    localparam int unsigned OPERAND_WIDTH = 32;

    typedef enum logic [2:0] {
        MS_B  = 3'd0,
        MS_H  = 3'd1,
        MS_W  = 3'd2,
        MS_BU = 3'd4,
        MS_HU = 3'd5
    } mem_size_e;

    typedef enum logic [1:0] {
        DR_IDLE,
        DR_WAIT,
        DR_RESP
    } dmem_rsp_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for loads and stores: lane enables, store shift,
// load extraction with sign/zero extension, and alignment checking.
module lsu_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [2:0]               size,
    input  logic [1:0]               off,
    input  logic [OPERAND_WIDTH-1:0] wdata,
    input  logic [OPERAND_WIDTH-1:0] rword,
    output logic [3:0]               byte_en,
    output logic [OPERAND_WIDTH-1:0] wdata_shifted,
    output logic [OPERAND_WIDTH-1:0] rdata,
    output logic                     misaligned
);

    mem_size_e                size_e;
    logic [OPERAND_WIDTH-1:0] rshifted;

    assign size_e        = mem_size_e'(size);
    assign wdata_shifted = wdata << {off, 3'b000};
    assign rshifted      = rword >> {off, 3'b000};

    always_comb begin
        byte_en    = 4'b0000;
        rdata      = '0;
        misaligned = 1'b0;
        case (size_e)
            MS_B: begin
                byte_en = 4'b0001 << off;
                rdata   = {{24{rshifted[7]}}, rshifted[7:0]};
            end
            MS_BU: begin
                byte_en = 4'b0001 << off;
                rdata   = {24'd0, rshifted[7:0]};
            end
            MS_H: begin
                misaligned = off[0];
                byte_en    = 4'b0011 << off;
                rdata      = {{16{rshifted[15]}}, rshifted[15:0]};
            end
            MS_HU: begin
                misaligned = off[0];
                byte_en    = 4'b0011 << off;
                rdata      = {16'd0, rshifted[15:0]};
            end
            MS_W: begin
                misaligned = (off != 2'd0);
                byte_en    = 4'b1111;
                rdata      = rshifted;
            end
            default: misaligned = 1'b1;  // undefined funct3 encodings
        endcase
        if (misaligned) begin
            byte_en = 4'b0000;
            rdata   = '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding request, programmable wait states,
// byte-lane stores and registered, extended load responses.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [2:0]               req_size,
    input  logic [OPERAND_WIDTH-1:0] req_addr,
    input  logic [OPERAND_WIDTH-1:0] req_wdata,
    output logic                     rsp_valid,
    output logic [OPERAND_WIDTH-1:0] rsp_rdata,
    output logic                     rsp_error
);

    localparam int unsigned IdxW = $clog2(DEPTH);

    dmem_rsp_state_e          state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [IdxW+1:0]          addr_q;
    logic [2:0]               size_q;
    logic                     write_q;
    logic [OPERAND_WIDTH-1:0] wdata_q;
    logic [OPERAND_WIDTH-1:0] rdata_q, rdata_d;
    logic                     error_q, error_d;

    logic [31:0]              mem [DEPTH];

    logic                     enter_resp;
    logic [IdxW+1:0]          cur_addr;
    logic [2:0]               cur_size;
    logic                     cur_write;
    logic [OPERAND_WIDTH-1:0] cur_wdata;
    logic [IdxW-1:0]          cur_idx;
    logic [3:0]               byte_en;
    logic [OPERAND_WIDTH-1:0] wdata_sh;
    logic [OPERAND_WIDTH-1:0] al_rdata;
    logic                     misaligned;
    logic                     unused_addr;

    assign unused_addr = ^req_addr[OPERAND_WIDTH-1:IdxW+2];

    // With no wait states RESP is entered straight from IDLE, so the live
    // request inputs must drive the datapath in that cycle.
    always_comb begin
        if (state_q == DR_IDLE) begin
            cur_addr  = req_addr[IdxW+1:0];
            cur_size  = req_size;
            cur_write = req_write;
            cur_wdata = req_wdata;
        end else begin
            cur_addr  = addr_q;
            cur_size  = size_q;
            cur_write = write_q;
            cur_wdata = wdata_q;
        end
    end

    assign cur_idx = cur_addr[IdxW+1:2];

    lsu_lane_align u_align (
        .size          (cur_size),
        .off           (cur_addr[1:0]),
        .wdata         (cur_wdata),
        .rword         (mem[cur_idx]),
        .byte_en       (byte_en),
        .wdata_shifted (wdata_sh),
        .rdata         (al_rdata),
        .misaligned    (misaligned)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        enter_resp = 1'b0;
        rdata_d    = '0;
        error_d    = 1'b0;
        case (state_q)
            DR_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = DR_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = DR_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            DR_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d    = DR_RESP;
                    enter_resp = 1'b1;
                end
            end
            DR_RESP: begin
                rsp_valid = 1'b1;
                state_d   = DR_IDLE;
                cnt_d     = 4'd0;
            end
            default: state_d = DR_IDLE;
        endcase
        if (enter_resp) begin
            rdata_d = (cur_write || misaligned) ? '0 : al_rdata;
            error_d = misaligned;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DR_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            size_q  <= 3'd0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            if (state_q == DR_IDLE && req_valid) begin
                addr_q  <= req_addr[IdxW+1:0];
                size_q  <= req_size;
                write_q <= req_write;
                wdata_q <= req_wdata;
            end
        end
    end

    // Storage survives reset; the commit is gated so a reset never writes.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_write && !misaligned && rst) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[cur_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_error = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: byte-array reference model, per-cycle
// compare process, directed literal checks and randomized traffic.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned WAIT  = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_size = 3'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    dmem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          due;
    } req_t;

    logic [7:0] mb [DEPTH*4];
    req_t       pend[$];
    int         acc_log[$];
    int         cyc = 0;
    int         last_acc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference semantics: storage as a flat byte array, funct3 decoded to a
    // byte count and a signedness flag.
    function automatic void model_apply(input req_t r, output logic [31:0] rd, output logic er);
        int     n;
        bit     sgn;
        int     idx;
        int     off;
        longint v;
        case (r.sz)
            3'd0:    begin n = 1; sgn = 1; end
            3'd1:    begin n = 2; sgn = 1; end
            3'd2:    begin n = 4; sgn = 0; end
            3'd4:    begin n = 1; sgn = 0; end
            3'd5:    begin n = 2; sgn = 0; end
            default: begin n = 0; sgn = 0; end
        endcase
        idx = int'((r.addr >> 2) % DEPTH);
        off = int'(r.addr % 4);
        rd  = '0;
        er  = 1'b0;
        if (n == 0 || (off % n) != 0) begin
            er = 1'b1;
        end else if (r.wr) begin
            for (int i = 0; i < n; i++) mb[idx*4 + off + i] = r.wdata[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v | (longint'(mb[idx*4 + off + i]) << (8*i));
            if (sgn && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
            rd = v[31:0];
        end
    endfunction

    // Accept monitor: records every handshake and when its response is due.
    always @(posedge clk or negedge rst_n) begin
        req_t r;
        if (!rst_n) begin
            pend.delete();
        end else begin
            if (req_valid && req_ready) begin
                r.wr    = req_write;
                r.sz    = req_size;
                r.addr  = req_addr;
                r.wdata = req_wdata;
                r.due   = cyc + 1 + WAIT;
                pend.push_back(r);
                acc_log.push_back(cyc);
                last_acc = cyc;
            end
            cyc++;
        end
    end

    // Compare process: every cycle, outputs must match the model's timeline.
    always @(negedge clk) begin
        logic [31:0] erd;
        logic        eer;
        logic        ev;
        while (pend.size() > 0 && pend[0].due < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missed_response: got none, expected response due at cycle %0d",
                     pend[0].due);
            void'(pend.pop_front());
        end
        ev = (pend.size() > 0) && (pend[0].due == cyc);
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
        check("req_ready", {31'd0, req_ready}, {31'd0, pend.size() == 0});
        erd = '0;
        eer = 1'b0;
        if (ev) begin
            model_apply(pend[0], erd, eer);
            void'(pend.pop_front());
        end
        check("rsp_rdata", rsp_rdata, erd);
        check("rsp_error", {31'd0, rsp_error}, {31'd0, eer});
    end

    task automatic drive_idle();
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_size  = 3'($urandom_range(0, 7));
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic issue(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output logic er,
                         output int lat);
        bit done;
        @(negedge clk);
        #1;
        req_valid = 1'b1;
        req_write = wr;
        req_size  = sz;
        req_addr  = a;
        req_wdata = d;
        done = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            if (req_ready) begin
                @(posedge clk);
                done = 1;
            end else begin
                @(negedge clk);
                #1;
            end
        end
        #1;
        drive_idle();
        rd  = '0;
        er  = 1'b0;
        lat = -1;
        if (!done) begin
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) begin
                rd   = rsp_rdata;
                er   = rsp_error;
                lat  = cyc - last_acc;
                done = 1;
            end
        end
        if (!done) check("response_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_req(input string name, input logic wr, input logic [2:0] sz,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd;
        logic        er;
        int          lat;
        issue(wr, sz, a, d, rd, er, lat);
        check({name, "_rdata"}, rd, exp_rd);
        check({name, "_error"}, {31'd0, er}, {31'd0, exp_er});
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [2:0]  sz;
        logic [31:0] a;

        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        check("reset_error", {31'd0, rsp_error}, 32'd0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < int'(DEPTH); i++) begin
            issue(1'b1, 3'd2, 32'(i * 4), $urandom, rd, er, lat);
        end

        issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check("sw_latency", 32'(lat), 32'd2);
        check("sw_rdata", rd, 32'd0);
        issue(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat);
        check("lw_latency", 32'(lat), 32'd2);
        check("lw_rdata", rd, 32'hDEADBEEF);

        expect_req("sb", 1'b1, 3'd0, 32'h13, 32'h0000_0080, 32'h0, 1'b0);
        expect_req("lb", 1'b0, 3'd0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
        expect_req("lbu", 1'b0, 3'd4, 32'h13, 32'h0, 32'h00000080, 1'b0);
        expect_req("lw_after_sb", 1'b0, 3'd2, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);

        expect_req("sh", 1'b1, 3'd1, 32'h12, 32'h0000_8001, 32'h0, 1'b0);
        expect_req("lh", 1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFF8001, 1'b0);
        expect_req("lhu", 1'b0, 3'd5, 32'h12, 32'h0, 32'h00008001, 1'b0);
        expect_req("lh_mis", 1'b0, 3'd1, 32'h11, 32'h0, 32'h0, 1'b1);
        expect_req("lw_after_sh", 1'b0, 3'd2, 32'h10, 32'h0, 32'h8001BEEF, 1'b0);

        expect_req("sw20", 1'b1, 3'd2, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
        expect_req("sw_mis", 1'b1, 3'd2, 32'h22, 32'h12345678, 32'h0, 1'b1);
        expect_req("lw20", 1'b0, 3'd2, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
        expect_req("sz_undef", 1'b0, 3'd3, 32'h20, 32'h0, 32'h0, 1'b1);

        expect_req("sw_wrap", 1'b1, 3'd2, 32'h400, 32'hA5A55A5A, 32'h0, 1'b0);
        expect_req("lw_alias", 1'b0, 3'd2, 32'h0, 32'h0, 32'hA5A55A5A, 1'b0);

        // Held-valid throughput: one accept every WAIT+2 cycles.
        @(negedge clk);
        #1;
        acc_log.delete();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 3'd2;
        req_addr  = 32'h0;
        repeat (10) @(posedge clk);
        #1;
        drive_idle();
        repeat (6) @(negedge clk);
        check("held_accepts", 32'(acc_log.size()), 32'd4);
        for (int i = 1; i < acc_log.size(); i++) begin
            check("held_spacing", 32'(acc_log[i] - acc_log[i-1]), 32'd3);
        end

        // Reset during the wait state of a store.
        expect_req("sw30", 1'b1, 3'd2, 32'h30, 32'h11223344, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 3'd2;
        req_addr  = 32'h30;
        req_wdata = 32'h99999999;
        @(posedge clk);
        #1;
        drive_idle();
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        repeat (4) @(negedge clk);
        expect_req("lw30_old", 1'b0, 3'd2, 32'h30, 32'h0, 32'h11223344, 1'b0);

        // Randomized traffic; the compare process carries the checking.
        for (int k = 0; k < 300; k++) begin
            sz = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(sz[0] ? 1 : (sz[1] ? 3 : 0));
            issue(1'($urandom_range(0, 1)), sz, a, $urandom, rd, er, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

endmodule
